// File: rtl/uc_pkg.sv
// uc_pkg: opcodes, FSM state encoding, ALU op codes and control word shared by the control unit.
package uc_pkg;
  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_WAIT = 2'd3
  } state_t;
  localparam logic [5:0] OP_LI   = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000100;
  localparam logic [5:0] OP_JZ   = 6'b000101;
  localparam logic [5:0] OP_JNZ  = 6'b000110;
  localparam logic [5:0] OP_HALT = 6'b000111;
  localparam logic [2:0] ALU_NONE = 3'b000;
  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] op;
    logic       halt;
    logic       ill;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, wez: 1'b0,
                                 op: ALU_NONE, halt: 1'b0, ill: 1'b0};
endpackage

// File: rtl/uc_decod.sv
// uc_decod: pure combinational Opcode/z to control-word decoder.
module uc_decod
  import uc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       z,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = CTRL_NOP;
    if (opcode[5]) begin
      ctrl.op  = opcode[4:2];
      ctrl.we3 = 1'b1;
      ctrl.wez = 1'b1;
    end else if (opcode[5:2] == OP_LI[5:2]) begin
      ctrl.we3   = 1'b1;
      ctrl.s_inm = 1'b1;
    end else if (opcode == OP_J) ctrl.s_inc = 1'b0;
    else if (opcode == OP_JZ) ctrl.s_inc = ~z;
    else if (opcode == OP_JNZ) ctrl.s_inc = z;
    else if (opcode == OP_HALT) ctrl.halt = 1'b1;
    else ctrl.ill = 1'b1;
  end
endmodule

// File: rtl/uc_secuencial.sv
// uc_secuencial: control unit with run-control FSM, retired counter and sticky illegal flag.
// Optional single-step mode is enabled by defining SINGLE_STEP_EN.
module uc_secuencial
  import uc_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    Opcode,
  input  logic          z,
  input  logic          step,
  output logic          s_inc,
  output logic          s_inm,
  output logic          we3,
  output logic          wez,
  output logic [2:0]    Op,
  output logic          pc_en,
  output logic          halted,
  output logic          illegal,
  output logic [CW-1:0] n_instr
);
  ctrl_t         ctrl;
  state_t        state_q, state_d;
  logic [CW-1:0] n_instr_q, n_instr_d;
  logic          illegal_q, illegal_d;
  logic          run, go;
  state_t        idle_st;
`ifdef SINGLE_STEP_EN
  assign idle_st = S_WAIT;
  assign go      = step;
`else
  logic unused_step;
  assign unused_step = step;
  assign idle_st     = S_RUN;
  assign go          = 1'b1;
`endif
  uc_decod u_decod (.opcode(Opcode), .z(z), .ctrl(ctrl));
  assign run = state_q == S_RUN;
  always_comb begin
    s_inc     = run ? ctrl.s_inc : 1'b1;
    s_inm     = run & ctrl.s_inm;
    we3       = run & ctrl.we3;
    wez       = run & ctrl.wez;
    Op        = run ? ctrl.op : ALU_NONE;
    pc_en     = run & ~ctrl.halt;
    halted    = state_q == S_HALT;
    illegal   = illegal_q;
    n_instr   = n_instr_q;
    illegal_d = illegal_q | (run & ctrl.ill);
    n_instr_d = (run && !(&n_instr_q)) ? n_instr_q + 1'b1 : n_instr_q;
    state_d   = state_q;
    unique case (state_q)
      S_INIT:  state_d = idle_st;
      S_RUN:   state_d = ctrl.halt ? S_HALT : idle_st;
      S_WAIT:  state_d = go ? S_RUN : S_WAIT;
      default: state_d = S_HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_INIT;
      n_instr_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_instr_q <= n_instr_d;
      illegal_q <= illegal_d;
    end
  end
endmodule

// File: tb/tb_uc_secuencial.sv
// tb_uc_secuencial: directed-vector bench for uc_secuencial (CW=16 and CW=4 instances).
module tb_uc_secuencial;
  logic        clk = 1'b0;
  logic        reset, z, step;
  logic [5:0]  Opcode;
  logic        s_inc, s_inm, we3, wez, pc_en, halted, illegal;
  logic [2:0]  Op;
  logic [15:0] n_instr;
  logic        s_inc4, s_inm4, we34, wez4, pc_en4, halted4, illegal4;
  logic [2:0]  Op4;
  logic [3:0]  n_instr4;
  int          nvec = 0;
  int          nerr = 0;
  int          exp_n = 0;
  always #5 clk = ~clk;
  uc_secuencial dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .step(step),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
    .pc_en(pc_en), .halted(halted), .illegal(illegal), .n_instr(n_instr)
  );
  uc_secuencial #(.CW(4)) dut4 (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .step(step),
    .s_inc(s_inc4), .s_inm(s_inm4), .we3(we34), .wez(wez4), .Op(Op4),
    .pc_en(pc_en4), .halted(halted4), .illegal(illegal4), .n_instr(n_instr4)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n, input int incr);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      exp_n += incr;
    end
  endtask
  task automatic chk_n();
    chk("n_instr", 32'(n_instr), 32'(exp_n));
    chk("n_instr_cw4", 32'(n_instr4), 32'(exp_n > 15 ? 15 : exp_n));
  endtask
  initial begin
    reset = 1'b1; z = 1'b0; step = 1'b0; Opcode = 6'b101100;
    tick(2, 0);
    reset = 1'b0;
    exp_n = 0;
    chk("init_pc_en", 32'(pc_en), 0);
    chk("init_we3", 32'(we3), 0);
    chk("init_halted", 32'(halted), 0);
    chk("init_illegal", 32'(illegal), 0);
    chk_n();
`ifdef SINGLE_STEP_EN
    tick(1, 0);
    chk("wait_pc_en", 32'(pc_en), 0);
    chk("wait_we3", 32'(we3), 0);
    tick(2, 0);
    chk("wait_hold_pc_en", 32'(pc_en), 0);
    chk_n();
    step = 1'b1;
    tick(1, 0);
    step = 1'b0;
    chk("step_pc_en", 32'(pc_en), 1);
    chk("step_we3", 32'(we3), 1);
    tick(1, 1);
    chk("back_wait_pc_en", 32'(pc_en), 0);
    chk_n();
    step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1, 0);
      chk("held_run_pc_en", 32'(pc_en), 1);
      tick(1, 1);
      chk("held_wait_pc_en", 32'(pc_en), 0);
    end
    step = 1'b0;
    chk_n();
    Opcode = 6'b000111;
    step = 1'b1;
    tick(1, 0);
    step = 1'b0;
    tick(1, 1);
    step = 1'b1;
    tick(2, 0);
    chk("ss_halted", 32'(halted), 1);
    chk("ss_halt_pc_en", 32'(pc_en), 0);
    chk_n();
`else
    tick(1, 0);
    chk("run_pc_en", 32'(pc_en), 1);
    chk("alu_op", 32'(Op), 32'h3);
    chk("alu_we3", 32'(we3), 1);
    chk("alu_wez", 32'(wez), 1);
    chk("alu_s_inm", 32'(s_inm), 0);
    chk("alu_s_inc", 32'(s_inc), 1);
    chk_n();
    tick(1, 1);
    chk_n();
    Opcode = 6'b000101; z = 1'b1; #1;
    chk("jz_z1", 32'(s_inc), 0);
    z = 1'b0; #1;
    chk("jz_z0", 32'(s_inc), 1);
    chk("jz_we3", 32'(we3), 0);
    Opcode = 6'b000110; z = 1'b1; #1;
    chk("jnz_z1", 32'(s_inc), 1);
    z = 1'b0; #1;
    chk("jnz_z0", 32'(s_inc), 0);
    Opcode = 6'b000100; #1;
    chk("j_s_inc", 32'(s_inc), 0);
    chk("j_wez", 32'(wez), 0);
    Opcode = 6'b000010; #1;
    chk("li_we3", 32'(we3), 1);
    chk("li_s_inm", 32'(s_inm), 1);
    chk("li_wez", 32'(wez), 0);
    tick(1, 1);
    chk("li_not_illegal", 32'(illegal), 0);
    Opcode = 6'b001000; #1;
    chk("nop_we3", 32'(we3), 0);
    chk("nop_s_inc", 32'(s_inc), 1);
    chk("illegal_lat", 32'(illegal), 0);
    tick(1, 1);
    chk("illegal_set", 32'(illegal), 1);
    Opcode = 6'b111100; #1;
    chk("alu7_op", 32'(Op), 32'h7);
    tick(20, 1);
    chk("illegal_sticky", 32'(illegal), 1);
    chk_n();
    Opcode = 6'b000111; #1;
    chk("halt_pc_en", 32'(pc_en), 0);
    chk("halt_we3", 32'(we3), 0);
    chk("halt_s_inc", 32'(s_inc), 1);
    tick(1, 1);
    Opcode = 6'b100100;
    for (int i = 0; i < 10; i++) begin
      tick(1, 0);
      chk("halted", 32'(halted), 1);
      chk("halted_pc_en", 32'(pc_en), 0);
      chk("halted_we3", 32'(we3), 0);
    end
    chk_n();
    reset = 1'b1;
    tick(1, 0);
    reset = 1'b0;
    exp_n = 0;
    chk("rst_halted", 32'(halted), 0);
    chk("rst_pc_en", 32'(pc_en), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk_n();
    tick(1, 0);
    chk("rerun_pc_en", 32'(pc_en), 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
